// File: rtl/bcd_st_pkg.sv
// Shared definitions for the BCD Avalon-ST adapters.
// Provides the width helper used to size pointers and occupancy counters,
// plus the readyLatency values the adapters are built around.
package bcd_st_pkg;

    // Both sides of the timing adapter use readyLatency 0.
    localparam int unsigned RDY_LAT_IN  = 32'd0;
    localparam int unsigned RDY_LAT_OUT = 32'd0;

    // Ceiling log2; clog2(1) = 0. Written as a bounded loop so it can be
    // evaluated in constant (parameter) context by any tool.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 32'd0) ? (value - 32'd1) : 32'd0;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (v != 32'd0) begin
                r = r + 32'd1;
                v = v >> 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_st_fifo_mem.sv
// Payload storage for the timing adapter: DEPTH entries of DATA_W bits,
// one synchronous write port and one asynchronous read port. The array is
// deliberately not reset; occupancy tracking in the parent decides which
// entries are meaningful.
//   clk      clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write payload
//   raddr_i  read address
//   rdata_o  read payload (combinational from the array)
module bcd_st_fifo_mem
    import bcd_st_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bcd_st_timing_fifo_adt.sv
// Avalon-ST timing adapter with a DEPTH-entry elastic buffer.
// Absorbs downstream backpressure; when the source cannot be backpressured
// (USE_IN_READY=0) a beat arriving at a full buffer with no pop is dropped,
// flagged in a sticky overflow bit and counted in a saturating counter.
//   clk / reset_n           clock, async active-low reset
//   in_valid/in_data/in_ready     upstream beat interface
//   out_valid/out_data/out_ready  downstream beat interface
//   fill                    current occupancy, 0..DEPTH
//   overflow / drop_count   drop reporting, cleared by clr_overflow
//   clr_overflow            synchronous clear of the drop reporting
module bcd_st_timing_fifo_adt
    import bcd_st_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 4,
    parameter bit          USE_IN_READY = 1'b0,
    parameter int unsigned CNT_W        = 16,
    localparam int unsigned FILL_W      = clog2(DEPTH + 32'd1),
    localparam int unsigned PTR_W       = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [FILL_W-1:0] fill,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count,
    input  logic              clr_overflow
);

    localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic drop_s;

    assign full_s  = (fill_q == FULL_LVL);
    assign empty_s = (fill_q == '0);
    assign pop_s   = !empty_s && out_ready;

    // Push/drop decision. With backpressure the full test uses registered
    // state only, so a full buffer refuses even if it is popped this cycle.
    // Without backpressure a simultaneous pop frees the slot for the beat.
    always_comb begin
        push_s = 1'b0;
        drop_s = 1'b0;
        if (USE_IN_READY) begin
            push_s = in_valid && !full_s;
            drop_s = 1'b0;
        end else begin
            push_s = in_valid && (!full_s || pop_s);
            drop_s = in_valid && full_s && !pop_s;
        end
    end

    // Next-state for pointers, occupancy and drop reporting.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase

        // A clear wins over a drop in the same cycle; that drop is lost.
        if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State registers; reset empties the buffer and clears drop reporting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    bcd_st_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (out_data)
    );

    // All outputs below derive from registered state only.
    assign in_ready   = USE_IN_READY ? !full_s : 1'b1;
    assign out_valid  = !empty_s;
    assign fill       = fill_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_bcd_st_timing_fifo_adt.sv
// Bench for bcd_st_timing_fifo_adt. Three instances:
//   d0: DEPTH=4, no upstream backpressure, CNT_W=2 (drop/saturation tests)
//   d1: DEPTH=4, upstream honours in_ready (pass-through, fill, reset)
//   d2: DEPTH=2, upstream honours in_ready (random wrap-around)
// A behavioural queue model per instance predicts handshakes and flags each
// cycle; accepted beats are pushed to a scoreboard and popped on output.
module tb_bcd_st_timing_fifo_adt;

    logic clk;
    logic reset_n;
    logic [2:0] iv;
    logic [2:0] ordy;
    logic [2:0] clr;
    logic [7:0] idat [3];

    wire  [2:0] irdy_w;
    wire  [2:0] ovld_w;
    wire  [2:0] ovf_w;
    wire  [7:0] odat_w [3];
    wire  [2:0]  f0, f1;
    wire  [1:0]  f2;
    wire  [1:0]  c0;
    wire  [15:0] c1, c2;
    wire  [15:0] fill_w [3];
    wire  [15:0] cnt_w [3];

    assign fill_w[0] = {13'd0, f0};
    assign fill_w[1] = {13'd0, f1};
    assign fill_w[2] = {14'd0, f2};
    assign cnt_w[0]  = {14'd0, c0};
    assign cnt_w[1]  = c1;
    assign cnt_w[2]  = c2;

    bcd_st_timing_fifo_adt #(.DATA_W(8), .DEPTH(4), .USE_IN_READY(1'b0), .CNT_W(2)) d0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_data(idat[0]),
        .in_ready(irdy_w[0]), .out_valid(ovld_w[0]), .out_data(odat_w[0]),
        .out_ready(ordy[0]), .fill(f0), .overflow(ovf_w[0]), .drop_count(c0),
        .clr_overflow(clr[0]));

    bcd_st_timing_fifo_adt #(.DATA_W(8), .DEPTH(4), .USE_IN_READY(1'b1), .CNT_W(16)) d1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_data(idat[1]),
        .in_ready(irdy_w[1]), .out_valid(ovld_w[1]), .out_data(odat_w[1]),
        .out_ready(ordy[1]), .fill(f1), .overflow(ovf_w[1]), .drop_count(c1),
        .clr_overflow(clr[1]));

    bcd_st_timing_fifo_adt #(.DATA_W(8), .DEPTH(2), .USE_IN_READY(1'b1), .CNT_W(16)) d2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_data(idat[2]),
        .in_ready(irdy_w[2]), .out_valid(ovld_w[2]), .out_data(odat_w[2]),
        .out_ready(ordy[2]), .fill(f2), .overflow(ovf_w[2]), .drop_count(c2),
        .clr_overflow(clr[2]));

    localparam int DEP  [3] = '{4, 4, 2};
    localparam int UIR  [3] = '{0, 1, 1};
    localparam int CMAX [3] = '{3, 65535, 65535};

    int         ncmp = 0;
    int         nerr = 0;
    int         mf   [3];
    int         movf [3];
    int         mcnt [3];
    int         npop [3];
    logic       acc  [3];
    logic [7:0] sbq  [3][$];
    logic       t7_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model, evaluated on the falling edge while inputs are stable.
    initial begin
        for (int k = 0; k < 3; k++) begin
            mf[k] = 0; movf[k] = 0; mcnt[k] = 0; npop[k] = 0; acc[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                for (int k = 0; k < 3; k++) begin
                    mf[k] = 0; movf[k] = 0; mcnt[k] = 0; npop[k] = 0; acc[k] = 1'b0;
                    sbq[k].delete();
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    logic full, pop, push, drop, exp_rdy;
                    full    = (mf[k] == DEP[k]);
                    exp_rdy = (UIR[k] != 0) ? !full : 1'b1;
                    chk_eq($sformatf("d%0d_in_ready", k), {31'd0, irdy_w[k]}, {31'd0, exp_rdy});
                    chk_eq($sformatf("d%0d_out_valid", k), {31'd0, ovld_w[k]}, {31'd0, (mf[k] != 0)});
                    chk_eq($sformatf("d%0d_fill", k), {16'd0, fill_w[k]}, mf[k]);
                    chk_eq($sformatf("d%0d_overflow", k), {31'd0, ovf_w[k]}, movf[k]);
                    chk_eq($sformatf("d%0d_drop_count", k), {16'd0, cnt_w[k]}, mcnt[k]);
                    pop = (mf[k] != 0) && ordy[k];
                    if (pop) begin
                        chk_eq($sformatf("d%0d_out_data", k), {24'd0, odat_w[k]}, {24'd0, sbq[k][0]});
                        void'(sbq[k].pop_front());
                        npop[k]++;
                    end
                    if (UIR[k] != 0) begin
                        push = iv[k] && !full;
                        drop = 1'b0;
                    end else begin
                        push = iv[k] && (!full || pop);
                        drop = iv[k] && full && !pop;
                    end
                    if (push) sbq[k].push_back(idat[k]);
                    acc[k] = push;
                    mf[k]  = mf[k] + (push ? 1 : 0) - (pop ? 1 : 0);
                    if (clr[k]) begin
                        movf[k] = 0; mcnt[k] = 0;
                    end else if (drop) begin
                        movf[k] = 1;
                        if (mcnt[k] < CMAX[k]) mcnt[k]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat without regard to ready (source not backpressurable).
    task automatic drive(input int k, input logic [7:0] d);
        iv[k]   = 1'b1;
        idat[k] = d;
        tick();
    endtask

    // Present a beat and hold it until the model reports it was accepted.
    task automatic send(input int k, input logic [7:0] d);
        bit done;
        done    = 1'b0;
        iv[k]   = 1'b1;
        idat[k] = d;
        for (int n = 0; n < 60 && !done; n++) begin
            @(posedge clk);
            if (acc[k]) done = 1'b1;
        end
        if (!done) chk_eq("send_timeout", 32'd0, 32'd1);
        #1;
        iv[k] = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        iv = 3'b000; ordy = 3'b000; clr = 3'b000; t7_done = 1'b0;
        for (int k = 0; k < 3; k++) idat[k] = 8'h00;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk_eq($sformatf("rst_d%0d_out_valid", k), {31'd0, ovld_w[k]}, 32'd0);
            chk_eq($sformatf("rst_d%0d_fill", k), {16'd0, fill_w[k]}, 32'd0);
            chk_eq($sformatf("rst_d%0d_in_ready", k), {31'd0, irdy_w[k]}, 32'd1);
            chk_eq($sformatf("rst_d%0d_overflow", k), {31'd0, ovf_w[k]}, 32'd0);
            chk_eq($sformatf("rst_d%0d_drop_count", k), {16'd0, cnt_w[k]}, 32'd0);
        end
        #10 reset_n = 1'b1;
        tick();

        // Pass-through: one beat per cycle, each visible one cycle later.
        ordy[1] = 1'b1;
        for (int d = 1; d <= 16; d++) send(1, 8'(d));
        repeat (3) tick();
        chk_eq("t1_drained", sbq[1].size(), 32'd0);
        chk_eq("t1_pops", npop[1], 32'd16);

        // Fill to full with backpressure, then release.
        ordy[1] = 1'b0;
        fork
            begin
                for (int d = 1; d <= 6; d++) send(1, 8'(d));
            end
            begin
                repeat (8) tick();
                chk_eq("t2_fill_full", {16'd0, fill_w[1]}, 32'd4);
                chk_eq("t2_in_ready_low", {31'd0, irdy_w[1]}, 32'd0);
                ordy[1] = 1'b1;
            end
        join
        repeat (8) tick();
        chk_eq("t2_fill_empty", {16'd0, fill_w[1]}, 32'd0);
        chk_eq("t2_pops", npop[1], 32'd22);
        ordy[1] = 1'b0;

        // Drop: 0xA4 and 0xA5 discarded.
        for (int i = 0; i < 6; i++) drive(0, 8'hA0 + 8'(i));
        iv[0] = 1'b0;
        chk_eq("t3_overflow", {31'd0, ovf_w[0]}, 32'd1);
        chk_eq("t3_drop_count", {16'd0, cnt_w[0]}, 32'd2);
        chk_eq("t3_fill", {16'd0, fill_w[0]}, 32'd4);
        ordy[0] = 1'b1;
        repeat (6) tick();
        ordy[0] = 1'b0;
        chk_eq("t3_pops", npop[0], 32'd4);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk_eq("t3_clr_overflow", {31'd0, ovf_w[0]}, 32'd0);
        chk_eq("t3_clr_count", {16'd0, cnt_w[0]}, 32'd0);

        // Simultaneous push and pop at full: stored, not dropped.
        for (int i = 0; i < 4; i++) drive(0, 8'hB0 + 8'(i));
        ordy[0] = 1'b1;
        drive(0, 8'hB4);
        iv[0] = 1'b0; ordy[0] = 1'b0;
        chk_eq("t4_fill", {16'd0, fill_w[0]}, 32'd4);
        chk_eq("t4_overflow", {31'd0, ovf_w[0]}, 32'd0);
        chk_eq("t4_drop_count", {16'd0, cnt_w[0]}, 32'd0);
        ordy[0] = 1'b1;
        repeat (6) tick();
        ordy[0] = 1'b0;
        chk_eq("t4_pops", npop[0], 32'd9);

        // Saturation with a 2-bit counter, then clear coincident with a drop.
        for (int i = 0; i < 9; i++) drive(0, 8'hC0 + 8'(i));
        iv[0] = 1'b0;
        chk_eq("t5_saturated", {16'd0, cnt_w[0]}, 32'd3);
        clr[0] = 1'b1;
        drive(0, 8'hD0);
        iv[0] = 1'b0; clr[0] = 1'b0;
        chk_eq("t5_clr_overflow", {31'd0, ovf_w[0]}, 32'd0);
        chk_eq("t5_clr_count", {16'd0, cnt_w[0]}, 32'd0);
        ordy[0] = 1'b1;
        repeat (6) tick();
        ordy[0] = 1'b0;

        // Reset mid-stream with three beats buffered.
        for (int i = 0; i < 3; i++) send(1, 8'hE0 + 8'(i));
        chk_eq("t6_fill_before", {16'd0, fill_w[1]}, 32'd3);
        #1 reset_n = 1'b0;
        #1;
        chk_eq("t6_async_out_valid", {31'd0, ovld_w[1]}, 32'd0);
        chk_eq("t6_async_fill", {16'd0, fill_w[1]}, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        tick();
        ordy[1] = 1'b1;
        repeat (4) tick();
        chk_eq("t6_no_stale", {31'd0, ovld_w[1]}, 32'd0);
        chk_eq("t6_no_pops", npop[1], 32'd0);
        ordy[1] = 1'b0;

        // Wrap-around on the 2-deep instance with random backpressure.
        fork
            begin
                for (int i = 0; i < 100; i++) send(2, 8'($urandom_range(0, 255)));
                t7_done = 1'b1;
            end
            begin
                for (int n = 0; n < 5000 && !t7_done; n++) begin
                    ordy[2] = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        ordy[2] = 1'b1;
        repeat (5) tick();
        chk_eq("t7_drained", sbq[2].size(), 32'd0);
        chk_eq("t7_pops", npop[2], 32'd100);
        chk_eq("t7_overflow", {31'd0, ovf_w[2]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
